// File: rtl/dram_bank_pkg.sv
// Sizing helpers and parameter legality checks shared by the dram_bank slice.
package dram_pkg;

    function automatic int nb(input int dw);
        return dw / 8;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit params_ok(input int dw, input int rd_lat, input int depth);
        return (dw % 8 == 0) && (dw >= 8) && (dw <= 512) &&
               (rd_lat >= 2) && (rd_lat <= 4) && (depth >= 1);
    endfunction

endpackage

// File: rtl/dram_bank_if.sv
// Request/response channel between the LSU (master) and the RAM bank (slave).
interface dram_bank_if
    import dram_pkg::*;
#(
    parameter int DW = 64,
    parameter int AW = 16
);
    localparam int NB = nb(DW);

    logic          req_vld;
    logic          req_rdy;
    logic [NB-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic [NB-1:0] par_flip;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;

    modport master (
        output req_vld, we, addr, dat, par_flip, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_dat, rsp_err
    );

    modport slave (
        input  req_vld, we, addr, dat, par_flip, rsp_rdy,
        output req_rdy, rsp_vld, rsp_dat, rsp_err
    );
endinterface

// File: rtl/dram_bank_rsp_fifo.sv
// Show-ahead synchronous FIFO holding read responses; the head is visible while not empty.
module dram_rsp_fifo
    import dram_pkg::*;
#(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_dat,
    input  logic i_pop,
    output logic o_vld,
    output T     o_dat
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_vld = (r_cnt != '0);
    assign w_pop = i_pop & o_vld;
    // Empty head reads as zero so the outputs are clean straight out of reset.
    assign o_dat = o_vld ? r_mem[r_rd] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            if (i_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!i_push && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr] <= i_dat;
    end
endmodule

// File: rtl/dram_bank.sv
// Single-port RAM bank: byte-enable writes, pipelined reads, credit-bounded response FIFO.
// Optional per-byte even parity storage and checking: `define DRAM_BANK_PARITY_EN.
module dram_bank
    import dram_pkg::*;
#(
    parameter int DW        = 64,
    parameter int AW        = 16,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    dram_bank_if.slave  bus,
    output logic        o_busy
);
    localparam int NB = nb(DW);
    localparam int CW = cnt_w(RSP_DEPTH);

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          err;
    } rsp_t;

    if (!params_ok(DW, RD_LAT, RSP_DEPTH)) begin : g_bad_params
        $error("dram_bank: illegal DW/RD_LAT/RSP_DEPTH combination");
    end

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_s0_dat;
    logic          r_s0_vld;
    logic [CW-1:0] r_cnt;
    logic          w_acc, w_wr, w_rd, w_pop;
    logic          w_s0_err;
    rsp_t          w_s0;
    logic          w_push;
    rsp_t          w_push_ent;
    logic          w_rsp_vld;
    rsp_t          w_head;

    assign bus.req_rdy = (r_cnt < CW'(RSP_DEPTH));
    assign w_acc       = bus.req_vld & bus.req_rdy;
    assign w_wr        = w_acc & (|bus.we);
    assign w_rd        = w_acc & ~(|bus.we);
    assign w_pop       = w_rsp_vld & bus.rsp_rdy;
    assign o_busy      = (r_cnt != '0);

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_s0_vld <= 1'b0;
        end else begin
            r_s0_vld <= w_rd;
            if (w_rd && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_rd && w_pop) r_cnt <= r_cnt - 1'b1;
        end
    end

    // NOTE: the array and datapath registers take no reset; contents survive rst_n and valids gate their use.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.we[b]) r_mem[bus.addr][8*b +: 8] <= bus.dat[8*b +: 8];
            end
        end
        if (w_rd) r_s0_dat <= r_mem[bus.addr];
    end

`ifdef DRAM_BANK_PARITY_EN
    logic [NB-1:0] r_par [2**AW];
    logic [NB-1:0] r_s0_par;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.we[b]) r_par[bus.addr][b] <= (^bus.dat[8*b +: 8]) ^ bus.par_flip[b];
            end
        end
        if (w_rd) r_s0_par <= r_par[bus.addr];
    end

    // NOTE: default first in always_comb so no path leaves the output unassigned (no latch).
    always_comb begin
        w_s0_err = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if ((^r_s0_dat[8*b +: 8]) != r_s0_par[b]) w_s0_err = 1'b1;
        end
    end
`else
    logic w_unused_flip;
    assign w_unused_flip = ^bus.par_flip;
    assign w_s0_err      = 1'b0;
`endif

    assign w_s0.dat = r_s0_dat;
    assign w_s0.err = w_s0_err;

    if (RD_LAT == 2) begin : g_no_pipe
        assign w_push     = r_s0_vld;
        assign w_push_ent = w_s0;
    end else begin : g_pipe
        localparam int NP = RD_LAT - 2;
        rsp_t          r_pipe [NP];
        logic [NP-1:0] r_pipe_vld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pipe_vld <= '0;
            end else begin
                r_pipe_vld[0] <= r_s0_vld;
                for (int i = 1; i < NP; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end

        always_ff @(posedge clk) begin
            r_pipe[0] <= w_s0;
            for (int i = 1; i < NP; i++) r_pipe[i] <= r_pipe[i-1];
        end

        assign w_push     = r_pipe_vld[NP-1];
        assign w_push_ent = r_pipe[NP-1];
    end

    // Credits cap outstanding reads at RSP_DEPTH, so a push never meets a full FIFO.
    dram_rsp_fifo #(
        .T     (rsp_t),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (w_push),
        .i_dat  (w_push_ent),
        .i_pop  (w_pop),
        .o_vld  (w_rsp_vld),
        .o_dat  (w_head)
    );

    assign bus.rsp_vld = w_rsp_vld;
    assign bus.rsp_dat = w_head.dat;
    assign bus.rsp_err = w_head.err;
endmodule

// File: tb/tb_dram_bank.sv
// Self-checking bench for dram_bank: directed scenarios plus random traffic vs a queue-based model.
module tb_dram_bank;
    localparam int DW     = 64;
    localparam int AW     = 16;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

`ifdef DRAM_BANK_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic o_busy;

    dram_bank_if #(.DW(DW), .AW(AW)) bus ();

    dram_bank #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .RSP_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] dat;
        logic        err;
        int          due;
    } exp_t;

    exp_t        pend_q[$];
    exp_t        vis_q[$];
    int          pop_cyc_q[$];
    logic [63:0] m_mem  [int];
    logic [7:0]  m_flip [int];
    int          m_cnt    = 0;
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    logic        t_acc, t_pop;
    logic [63:0] last_dat;
    logic        last_err;
    int          last_pop_cyc, last_acc_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input int a);
        return PAR_EN && m_flip.exists(a) && (m_flip[a] != 8'h00);
    endfunction

    task automatic drive(input logic vld, input logic [7:0] we, input logic [15:0] a,
                         input logic [63:0] d, input logic [7:0] flip);
        bus.req_vld  = vld;
        bus.we       = we;
        bus.addr     = a;
        bus.dat      = d;
        bus.par_flip = flip;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 16'h0, 64'h0, 8'h00);
    endtask

    // One clock: compare outputs with the model, then advance model and DUT together.
    task automatic tick();
        exp_t e;
        int   a;
        check("req_rdy", bus.req_rdy, m_cnt < DEPTH);
        check("rsp_vld", bus.rsp_vld, vis_q.size() != 0);
        check("busy",    o_busy,      m_cnt != 0);
        t_acc = bus.req_vld && bus.req_rdy;
        t_pop = bus.rsp_vld && bus.rsp_rdy;
        if (t_pop && vis_q.size() != 0) begin
            check("rsp_dat", bus.rsp_dat, vis_q[0].dat);
            check("rsp_err", bus.rsp_err, vis_q[0].err);
            last_dat     = bus.rsp_dat;
            last_err     = bus.rsp_err;
            last_pop_cyc = cyc;
            pop_cyc_q.push_back(cyc);
            void'(vis_q.pop_front());
            m_cnt--;
        end
        foreach (pend_q[i]) pend_q[i].due--;
        while (pend_q.size() != 0 && pend_q[0].due == 0) vis_q.push_back(pend_q.pop_front());
        if (t_acc) begin
            last_acc_cyc = cyc;
            a = int'(bus.addr);
            if (bus.we == 8'h00) begin
                e.dat = m_mem[a];
                e.err = exp_err(a);
                e.due = RD_LAT - 1;
                pend_q.push_back(e);
                m_cnt++;
            end else begin
                if (!m_flip.exists(a)) m_flip[a] = 8'h00;
                if (!m_mem.exists(a))  m_mem[a]  = 'x;
                for (int b = 0; b < 8; b++) begin
                    if (bus.we[b]) begin
                        m_mem[a][8*b +: 8] = bus.dat[8*b +: 8];
                        m_flip[a][b]       = bus.par_flip[b];
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue(input logic [7:0] we, input logic [15:0] a, input logic [63:0] d,
                         input logic [7:0] flip);
        int n = 0;
        drive(1'b1, we, a, d, flip);
        do begin
            tick();
            n++;
        end while (!t_acc && n < 20);
        check("accept", t_acc, 1'b1);
        idle();
    endtask

    task automatic drain();
        int n = 0;
        idle();
        bus.rsp_rdy = 1'b1;
        while ((vis_q.size() != 0 || pend_q.size() != 0 || o_busy) && n < 50) begin
            tick();
            n++;
        end
        check("drained", o_busy, 1'b0);
    endtask

    initial begin
        int          acc_c, w_c, first_acc, i, n;
        logic [15:0] sa [6];
        logic [7:0]  we;
        int          r;

        idle();
        bus.rsp_rdy = 1'b0;
        #2;
        check("rst_rsp_vld", bus.rsp_vld, 1'b0);
        check("rst_rsp_dat", bus.rsp_dat, 64'h0);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_busy",    o_busy,      1'b0);
        check("rst_req_rdy", bus.req_rdy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.rsp_rdy = 1'b1;

        // Full write then read, with latency check.
        issue(8'hFF, 16'd5, 64'h1122334455667788, 8'h00);
        issue(8'h00, 16'd5, 64'h0, 8'h00);
        acc_c = last_acc_cyc;
        drain();
        check("rd5_dat", last_dat, 64'h1122334455667788);
        check("rd5_err", last_err, 1'b0);
        check("rd5_lat", last_pop_cyc - acc_c, RD_LAT);

        // Partial byte-enable write.
        issue(8'h0F, 16'd5, 64'hAAAAAAAA_DEADBEEF, 8'h00);
        issue(8'h00, 16'd5, 64'h0, 8'h00);
        drain();
        check("partial_dat", last_dat, 64'h11223344DEADBEEF);

        // Read on the edge right after a write sees the new data.
        issue(8'hFF, 16'd9, 64'h0F0E0D0C0B0A0908, 8'h00);
        w_c = last_acc_cyc;
        issue(8'h00, 16'd9, 64'h0, 8'h00);
        check("raw_b2b", last_acc_cyc - w_c, 1);
        drain();
        check("raw_dat", last_dat, 64'h0F0E0D0C0B0A0908);

        for (int k = 0; k < 16; k++) issue(8'hFF, 16'(32 + k), {$urandom, $urandom}, 8'h00);

        // Stall: responses blocked, credits run out after DEPTH reads.
        for (int k = 0; k < 6; k++) sa[k] = 16'(32 + k);
        bus.rsp_rdy = 1'b0;
        i = 0;
        repeat (6) begin
            drive(1'b1, 8'h00, sa[i], 64'h0, 8'h00);
            tick();
            if (t_acc) i++;
        end
        check("stall_accepts", i, DEPTH);
        check("stall_rdy", bus.req_rdy, 1'b0);
        check("stall_busy", o_busy, 1'b1);
        bus.rsp_rdy = 1'b1;
        n = 0;
        while (i < 6 && n < 30) begin
            drive(1'b1, 8'h00, sa[i], 64'h0, 8'h00);
            tick();
            if (t_acc) i++;
            n++;
        end
        check("stall_rest", i, 6);
        drain();

        // Streaming: one response per cycle.
        pop_cyc_q.delete();
        first_acc = -1;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 8'h00, 16'(32 + k), 64'h0, 8'h00);
            if (first_acc < 0) first_acc = cyc;
            tick();
            if (t_acc) n++;
        end
        drain();
        check("stream_accepts", n, 16);
        check("stream_rsps", pop_cyc_q.size(), 16);
        check("stream_first", pop_cyc_q[0] - first_acc, RD_LAT);
        check("stream_span", pop_cyc_q[15] - pop_cyc_q[0], 15);

        // Reset with reads queued: queue flushed, array kept.
        bus.rsp_rdy = 1'b0;
        issue(8'h00, 16'd33, 64'h0, 8'h00);
        issue(8'h00, 16'd34, 64'h0, 8'h00);
        issue(8'h00, 16'd35, 64'h0, 8'h00);
        tick();
        check("pre_rst_vld", bus.rsp_vld, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", bus.rsp_vld, 1'b0);
        check("mid_rst_rdy", bus.req_rdy, 1'b1);
        check("mid_rst_busy", o_busy, 1'b0);
        pend_q.delete();
        vis_q.delete();
        m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.rsp_rdy = 1'b1;
        check("post_rst_rdy", bus.req_rdy, 1'b1);
        issue(8'h00, 16'd5, 64'h0, 8'h00);
        drain();
        check("post_rst_dat", last_dat, 64'h11223344DEADBEEF);

`ifdef DRAM_BANK_PARITY_EN
        issue(8'hFF, 16'd20, 64'hCAFEF00D12345678, 8'h04);
        issue(8'h00, 16'd20, 64'h0, 8'h00);
        drain();
        check("par_flip_err", last_err, 1'b1);
        check("par_flip_dat", last_dat, 64'hCAFEF00D12345678);
        issue(8'hFF, 16'd20, 64'hCAFEF00D12345678, 8'h00);
        issue(8'h00, 16'd20, 64'h0, 8'h00);
        drain();
        check("par_clean_err", last_err, 1'b0);
`endif

        // Random mixed traffic with random response backpressure.
        repeat (300) begin
            r  = $urandom_range(0, 9);
            we = (r < 4) ? 8'h00 : ((r < 7) ? 8'hFF : 8'($urandom));
            drive($urandom_range(0, 3) != 0, we, 16'(32 + $urandom_range(0, 15)),
                  {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
            bus.rsp_rdy = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
